// File: rtl/microwave_sequencer.sv
// Microwave cook-cycle controller: keypad digit entry into the timer,
// IDLE/ENTRY/COOK/PAUSE/DONE sequencing, magnetron, count enable and beeper.
module microwave_sequencer #(
    parameter int MAX_DIGITS = 3,
    parameter int BEEP_SECS  = 3
) (
    input  logic       clk,
    input  logic       clearn,
    input  logic [9:0] keypad,
    input  logic       startn,
    input  logic       stopn,
    input  logic       door_closed,
    input  logic       zero,
    input  logic       pgt_1Hz,
    output logic [3:0] D,
    output logic       loadn,
    output logic       tclrn,
    output logic       enablen,
    output logic       mag_on,
    output logic       beep,
    output logic [2:0] state
);

    localparam int DCW = $clog2(MAX_DIGITS + 1);
    localparam int BCW = $clog2(BEEP_SECS + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ENTRY = 3'd1,
        COOK  = 3'd2,
        PAUSE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [9:0]       key_q, key_prev_q;
    logic             startn_q, startn_prev_q;
    logic             stopn_q, stopn_prev_q;
    logic [3:0]       d_q, d_d;
    logic             loadn_q, loadn_d;
    logic             tclrn_q, tclrn_d;
    logic             enablen_q, enablen_d;
    logic             mag_on_q, mag_on_d;
    logic             beep_q, beep_d;
    logic [DCW-1:0]   digit_cnt_q, digit_cnt_d;
    logic [BCW-1:0]   beep_cnt_q, beep_cnt_d;

    logic             key_ev, start_ev, stop_ev;
    logic [3:0]       digit;

    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            state_q       <= IDLE;
            key_q         <= '0;
            key_prev_q    <= '0;
            startn_q      <= 1'b1;
            startn_prev_q <= 1'b1;
            stopn_q       <= 1'b1;
            stopn_prev_q  <= 1'b1;
            d_q           <= '0;
            loadn_q       <= 1'b1;
            tclrn_q       <= 1'b1;
            enablen_q     <= 1'b1;
            mag_on_q      <= 1'b0;
            beep_q        <= 1'b0;
            digit_cnt_q   <= '0;
            beep_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            key_q         <= keypad;
            key_prev_q    <= key_q;
            startn_q      <= startn;
            startn_prev_q <= startn_q;
            stopn_q       <= stopn;
            stopn_prev_q  <= stopn_q;
            d_q           <= d_d;
            loadn_q       <= loadn_d;
            tclrn_q       <= tclrn_d;
            enablen_q     <= enablen_d;
            mag_on_q      <= mag_on_d;
            beep_q        <= beep_d;
            digit_cnt_q   <= digit_cnt_d;
            beep_cnt_q    <= beep_cnt_d;
        end
    end

    // A key counts only on the first cycle a single key appears after all-released.
    always_comb begin
        key_ev   = $onehot(key_q) && (key_prev_q == '0);
        start_ev = startn_prev_q && !startn_q;
        stop_ev  = stopn_prev_q && !stopn_q;
        digit    = '0;
        for (int unsigned i = 0; i < 10; i++) begin
            if (key_q[i]) digit = 4'(i);
        end
    end

    always_comb begin
        state_d     = state_q;
        d_d         = d_q;
        loadn_d     = 1'b1;
        tclrn_d     = 1'b1;
        digit_cnt_d = digit_cnt_q;
        beep_cnt_d  = beep_cnt_q;
        case (state_q)
            IDLE: begin
                if (key_ev) begin
                    d_d         = digit;
                    loadn_d     = 1'b0;
                    digit_cnt_d = DCW'(1);
                    state_d     = ENTRY;
                end
            end
            ENTRY: begin
                if (stop_ev) begin
                    tclrn_d     = 1'b0;
                    digit_cnt_d = '0;
                    state_d     = IDLE;
                end else if (start_ev && door_closed && !zero) begin
                    state_d = COOK;
                end else if (key_ev && (digit_cnt_q < DCW'(MAX_DIGITS))) begin
                    d_d         = digit;
                    loadn_d     = 1'b0;
                    digit_cnt_d = digit_cnt_q + DCW'(1);
                end
            end
            COOK: begin
                if (zero) begin
                    beep_cnt_d = '0;
                    state_d    = DONE;
                end else if (!door_closed || stop_ev) begin
                    state_d = PAUSE;
                end
            end
            PAUSE: begin
                if (stop_ev) begin
                    tclrn_d     = 1'b0;
                    digit_cnt_d = '0;
                    state_d     = IDLE;
                end else if (start_ev && door_closed) begin
                    state_d = COOK;
                end
            end
            DONE: begin
                if (stop_ev) begin
                    digit_cnt_d = '0;
                    state_d     = IDLE;
                end else if (key_ev) begin
                    d_d         = digit;
                    loadn_d     = 1'b0;
                    digit_cnt_d = DCW'(1);
                    state_d     = ENTRY;
                end else if (pgt_1Hz) begin
                    beep_cnt_d = beep_cnt_q + BCW'(1);
                    if (beep_cnt_d == BCW'(BEEP_SECS)) begin
                        digit_cnt_d = '0;
                        state_d     = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Levels are registered from the next state so they follow the transition edge.
    always_comb begin
        enablen_d = (state_d != COOK);
        mag_on_d  = (state_d == COOK);
        beep_d    = (state_d == DONE);
    end

    assign D       = d_q;
    assign loadn   = loadn_q;
    assign tclrn   = tclrn_q;
    assign enablen = enablen_q;
    assign mag_on  = mag_on_q;
    assign beep    = beep_q;
    assign state   = state_q;

endmodule
